// File: rtl/palette_pixel_pipe_pkg.sv
// Shared types and constants for the palette pixel stage.
// rgb_t is the default 8-bit-per-channel view of a {r,g,b} word.
package display_pkg;

  localparam int RGB_CH_W = 8;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pp_state_e;

  localparam rgb_t BLACK = '0;

endpackage

// File: rtl/palette_pixel_pipe_if.sv
// CPU-side palette write port and sticky error flags of the pixel stage.
// INDEX_W and CH_W must match the parameters of the attached pipe.
interface palette_pixel_pipe_if #(
  parameter int INDEX_W = 8,
  parameter int CH_W    = 8
);

  logic                pal_we;
  logic [INDEX_W-1:0]  pal_addr;
  logic [3*CH_W-1:0]   pal_wdata;
  logic                pal_ready;
  logic                err_clr;
  logic                oob_flag;
  logic                wr_err;

  modport master (
    output pal_we, pal_addr, pal_wdata, err_clr,
    input  pal_ready, oob_flag, wr_err
  );

  modport slave (
    input  pal_we, pal_addr, pal_wdata, err_clr,
    output pal_ready, oob_flag, wr_err
  );

endinterface

// File: rtl/palette_pixel_pipe_ram.sv
// Palette storage: one write port, one synchronous read-before-write read port.
// Kept free of reset and control logic so it maps onto block/distributed RAM.
module palette_ram #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd_q
);

  logic [DW-1:0] mem [DEPTH];

  // The read samples the array before this edge's write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    rd_q <= mem[ra];
  end

endmodule

// File: rtl/palette_pixel_pipe.sv
// Palette lookup pixel stage: index -> RGB with syncs/de delayed by the same two cycles.
// After reset an init sequencer clears every palette entry before CPU writes are accepted.
module palette_pixel_pipe
  import display_pkg::*;
#(
  parameter int               INDEX_W   = 8,
  parameter int               PAL_DEPTH = 10,
  parameter int               CH_W      = 8,
  parameter logic [3*CH_W-1:0] OOB_COLOR = 24'hFF00FF,
  parameter logic             SYNC_IDLE = 1'b1
) (
  input  logic                vgaClk,
  input  logic                rst,
  input  logic                videoOn,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [INDEX_W-1:0]  color_index,
  palette_pixel_pipe_if.slave cpu,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                de_out
);

  localparam int DW = 3 * CH_W;
  localparam int AW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int CW = $clog2(PAL_DEPTH + 1);
  localparam logic [INDEX_W:0] DEPTH_X    = (INDEX_W + 1)'(PAL_DEPTH);
  localparam logic [CW-1:0]    LAST_ENTRY = CW'(PAL_DEPTH - 1);

  pp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          run;
  logic          wr_acc;
  logic          wr_oob;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_rd;
  logic          idx_oob;

  logic          s1_vid_q, s1_vid_d;
  logic          s1_hs_q, s1_hs_d;
  logic          s1_vs_q, s1_vs_d;
  logic          s1_oob_q, s1_oob_d;
  logic [DW-1:0] rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          oob_flag_q, oob_flag_d;
  logic          wr_err_q, wr_err_d;

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT clears one entry per cycle and hands over to RUN after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_ENTRY) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    run    = (state_q == RUN);
    wr_acc = cpu.pal_we && run;
    wr_oob = wr_acc && !({1'b0, cpu.pal_addr} < DEPTH_X);
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = '0;
    if (!run) begin
      ram_we = 1'b1;
      ram_wa = cnt_q[AW-1:0];
    end else if (wr_acc && !wr_oob) begin
      ram_we = 1'b1;
      ram_wa = cpu.pal_addr[AW-1:0];
      ram_wd = cpu.pal_wdata;
    end
  end

  assign cpu.pal_ready = run;
  assign cpu.oob_flag  = oob_flag_q;
  assign cpu.wr_err    = wr_err_q;

  // Out-of-range indices read entry 0 so the RAM is never addressed past its depth.
  assign idx_oob = !({1'b0, color_index} < DEPTH_X);
  assign ram_ra  = idx_oob ? '0 : color_index[AW-1:0];

  palette_ram #(
    .DEPTH (PAL_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk  (vgaClk),
    .we   (ram_we),
    .wa   (ram_wa),
    .wd   (ram_wd),
    .ra   (ram_ra),
    .rd_q (ram_rd)
  );

  always_comb begin
    s1_vid_d   = run && videoOn;
    s1_hs_d    = run ? hsync_in : SYNC_IDLE;
    s1_vs_d    = run ? vsync_in : SYNC_IDLE;
    s1_oob_d   = idx_oob;
    rgb_d      = DW'(BLACK);
    if (s1_vid_q) begin
      rgb_d = s1_oob_q ? OOB_COLOR : ram_rd;
    end
    de_d       = s1_vid_q;
    hs_d       = s1_hs_q;
    vs_d       = s1_vs_q;
    oob_flag_d = oob_flag_q || (s1_vid_q && s1_oob_q);
    wr_err_d   = wr_err_q || wr_oob;
    if (cpu.err_clr) begin
      oob_flag_d = 1'b0;
      wr_err_d   = 1'b0;
    end
  end

  always_ff @(posedge vgaClk or negedge rst) begin
    if (!rst) begin
      s1_vid_q   <= 1'b0;
      s1_hs_q    <= SYNC_IDLE;
      s1_vs_q    <= SYNC_IDLE;
      s1_oob_q   <= 1'b0;
      rgb_q      <= DW'(BLACK);
      de_q       <= 1'b0;
      hs_q       <= SYNC_IDLE;
      vs_q       <= SYNC_IDLE;
      oob_flag_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      s1_vid_q   <= s1_vid_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_oob_q   <= s1_oob_d;
      rgb_q      <= rgb_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      oob_flag_q <= oob_flag_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign red       = rgb_q[3*CH_W-1 -: CH_W];
  assign green     = rgb_q[2*CH_W-1 -: CH_W];
  assign blue      = rgb_q[CH_W-1:0];
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule

// File: tb/tb_palette_pixel_pipe.sv
// Directed bench for palette_pixel_pipe: init timing, lookups, collisions, flags, reset.
// Stimulus changes on the falling edge; outputs are checked on the falling edge too.
module tb_palette_pixel_pipe;
  import display_pkg::*;

  localparam int INDEX_W   = 8;
  localparam int PAL_DEPTH = 10;
  localparam int CH_W      = 8;

  logic               vgaClk = 1'b0;
  logic               rst = 1'b0;
  logic               videoOn = 1'b0;
  logic               hsync_in = 1'b1;
  logic               vsync_in = 1'b1;
  logic [INDEX_W-1:0] color_index = '0;
  logic [CH_W-1:0]    red, green, blue;
  logic               hsync_out, vsync_out, de_out;

  int errors = 0;
  int checks = 0;

  palette_pixel_pipe_if #(.INDEX_W(INDEX_W), .CH_W(CH_W)) cpu ();

  palette_pixel_pipe #(
    .INDEX_W   (INDEX_W),
    .PAL_DEPTH (PAL_DEPTH),
    .CH_W      (CH_W),
    .OOB_COLOR (24'hFF00FF),
    .SYNC_IDLE (1'b1)
  ) dut (
    .vgaClk      (vgaClk),
    .rst         (rst),
    .videoOn     (videoOn),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .color_index (color_index),
    .cpu         (cpu),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de_out      (de_out)
  );

  always #5 vgaClk = ~vgaClk;

  task automatic tick();
    @(negedge vgaClk);
  endtask

  task automatic applyStimulus(input logic vid, input logic hs, input logic vs,
                               input logic [INDEX_W-1:0] idx);
    videoOn     = vid;
    hsync_in    = hs;
    vsync_in    = vs;
    color_index = idx;
  endtask

  task automatic cpuWrite(input logic [INDEX_W-1:0] addr, input logic [23:0] data);
    cpu.pal_we    = 1'b1;
    cpu.pal_addr  = addr;
    cpu.pal_wdata = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkPixel(input string tag, input logic [23:0] rgb, input logic de,
                            input logic hs, input logic vs);
    rgb_t px;
    px = '{r: red, g: green, b: blue};
    checkOutput({tag, ".rgb"}, {8'h00, px}, {8'h00, rgb});
    checkOutput({tag, ".de"}, {31'd0, de_out}, {31'd0, de});
    checkOutput({tag, ".hs"}, {31'd0, hsync_out}, {31'd0, hs});
    checkOutput({tag, ".vs"}, {31'd0, vsync_out}, {31'd0, vs});
  endtask

  initial begin
    cpu.pal_we    = 1'b0;
    cpu.pal_addr  = '0;
    cpu.pal_wdata = '0;
    cpu.err_clr   = 1'b0;

    // Reset state
    tick();
    checkPixel("reset", 24'h000000, 1'b0, 1'b1, 1'b1);
    checkOutput("reset.ready", {31'd0, cpu.pal_ready}, 32'd0);
    checkOutput("reset.oob", {31'd0, cpu.oob_flag}, 32'd0);
    checkOutput("reset.wrerr", {31'd0, cpu.wr_err}, 32'd0);

    // INIT: ready after exactly PAL_DEPTH edges; toggling inputs and writes ignored
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    cpuWrite(8'd2, 24'hABCDEF);
    for (int k = 1; k <= PAL_DEPTH; k++) begin
      tick();
      checkOutput($sformatf("init%0d.ready", k), {31'd0, cpu.pal_ready},
                  (k == PAL_DEPTH) ? 32'd1 : 32'd0);
      checkPixel($sformatf("init%0d", k), 24'h000000, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, k[0], ~k[0], 8'd3);
    end

    // RUN: load entries 3 and 5
    cpuWrite(8'd3, 24'h12AB34);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    cpuWrite(8'd5, 24'h000080);
    tick();
    cpu.pal_we = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 8'd3);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2);
    tick();
    checkPixel("idx3", 24'h12AB34, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'd5);
    cpuWrite(8'd5, 24'hFFFFFF);
    tick();
    cpu.pal_we = 1'b0;
    checkPixel("idx2_init_drop", 24'h000000, 1'b1, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'd5);
    tick();
    checkPixel("collide_old", 24'h000080, 1'b1, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'd12);
    tick();
    checkPixel("collide_new", 24'hFFFFFF, 1'b1, 1'b1, 1'b1);
    checkOutput("oob_before", {31'd0, cpu.oob_flag}, 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd12);
    tick();
    checkPixel("oob_active", 24'hFF00FF, 1'b1, 1'b1, 1'b1);
    checkOutput("oob_set", {31'd0, cpu.oob_flag}, 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd3);
    tick();
    checkPixel("oob_blank", 24'h000000, 1'b0, 1'b1, 1'b1);
    checkOutput("oob_sticky", {31'd0, cpu.oob_flag}, 32'd1);

    cpu.err_clr = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd12);
    tick();
    checkPixel("blank_idx3", 24'h000000, 1'b0, 1'b1, 1'b1);
    checkOutput("oob_cleared", {31'd0, cpu.oob_flag}, 32'd0);

    cpu.err_clr = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd12);
    tick();
    checkOutput("oob_blank_noset1", {31'd0, cpu.oob_flag}, 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    checkPixel("blank_oob", 24'h000000, 1'b0, 1'b1, 1'b1);
    checkOutput("oob_blank_noset2", {31'd0, cpu.oob_flag}, 32'd0);

    // err_clr wins over a same-edge set
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd12);
    tick();
    cpu.err_clr = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    checkPixel("oob_prio", 24'hFF00FF, 1'b1, 1'b1, 1'b1);
    checkOutput("oob_clr_prio", {31'd0, cpu.oob_flag}, 32'd0);

    // Write past the palette end
    cpu.err_clr = 1'b0;
    cpuWrite(8'd10, 24'hAAAAAA);
    tick();
    cpu.pal_we = 1'b0;
    checkOutput("wrerr_set", {31'd0, cpu.wr_err}, 32'd1);
    checkOutput("oob_still0", {31'd0, cpu.oob_flag}, 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd3);
    tick();
    checkPixel("entry0_intact", 24'h000000, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    checkPixel("entry3_intact", 24'h12AB34, 1'b1, 1'b1, 1'b1);
    checkOutput("wrerr_sticky", {31'd0, cpu.wr_err}, 32'd1);

    cpu.err_clr = 1'b1;
    tick();
    cpu.err_clr = 1'b0;
    checkOutput("wrerr_cleared", {31'd0, cpu.wr_err}, 32'd0);

    // Reset in the middle of a stream
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd3);
    tick();
    checkPixel("prereset", 24'h12AB34, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkPixel("async_reset", 24'h000000, 1'b0, 1'b1, 1'b1);
    checkOutput("async_reset.ready", {31'd0, cpu.pal_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= PAL_DEPTH; k++) begin
      tick();
      checkOutput($sformatf("reinit%0d.ready", k), {31'd0, cpu.pal_ready},
                  (k == PAL_DEPTH) ? 32'd1 : 32'd0);
      checkPixel($sformatf("reinit%0d", k), 24'h000000, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, k[0], 1'b1, 8'd3);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd3);
    tick();
    checkPixel("first_run_gap", 24'h000000, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    tick();
    checkPixel("entry3_cleared", 24'h000000, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palette_pixel_pipe.md
Name: palette_pixel_pipe

Overview:
- Parametrised palette-lookup pixel stage between the HDMI/VGA timing generator and the TMDS encoder.
- Maps a colour index to RGB through a runtime-writable palette.
- Delays hsync/vsync/videoOn by the same two-cycle latency as the pixel data, so all outputs stay aligned.
- Palette is cleared by an init sequencer after reset, then loaded by the CPU over a simple write port.

Parameters:
- INDEX_W, 8, colour index width.
- PAL_DEPTH, 10, palette entries (1..2**INDEX_W).
- CH_W, 8, bits per colour channel.
- OOB_COLOR, 24'hFF00FF, RGB output for index >= PAL_DEPTH (CH_W=8 packing {r,g,b}; generalised to 3*CH_W).
- SYNC_IDLE, 1'b1, hsync/vsync level driven during reset and INIT.

Ports:
- vgaClk  in  1  pixel clock; only clock.
- rst  in  1  asynchronous, active-low reset.
- videoOn  in  1  active-video qualifier.
- hsync_in  in  1  horizontal sync from timing generator.
- vsync_in  in  1  vertical sync from timing generator.
- color_index  in  INDEX_W  pixel colour index.
- pal_we  in  1  palette write request.
- pal_addr  in  INDEX_W  palette write address.
- pal_wdata  in  3*CH_W  {r,g,b} write data.
- pal_ready  out  1  high when writes are accepted.
- err_clr  in  1  clears sticky flags.
- oob_flag  out  1  sticky: out-of-range lookup during active video.
- wr_err  out  1  sticky: write to address >= PAL_DEPTH.
- red, green, blue  out  CH_W each  pixel colour.
- hsync_out, vsync_out, de_out  out  1  delayed syncs and data enable.

Behaviour:
- Reset (rst=0, async):
  - red/green/blue=0, de_out=0, hsync_out=vsync_out=SYNC_IDLE.
  - pal_ready=0, oob_flag=0, wr_err=0.
  - Init counter=0; FSM enters INIT.
- Reset mid-operation: the pipeline is flushed immediately and INIT restarts from entry 0, even if INIT had not finished.
- FSM INIT:
  - Writes 0 to entry cnt each cycle; cnt increments.
  - After entry PAL_DEPTH-1 is written, moves to RUN. INIT lasts exactly PAL_DEPTH cycles.
  - pal_ready=0; pal_we is ignored, not queued.
  - Pixel outputs are black; syncs are driven at SYNC_IDLE; de_out=0.
- FSM RUN: pal_ready=1; no exit except reset.
- Write handshake:
  - A write is accepted on a cycle with pal_we && pal_ready.
  - If pal_addr < PAL_DEPTH, the entry is updated at that edge.
  - Otherwise the write is dropped and wr_err is set.
- Lookup pipeline (RUN), fixed latency 2 cycles for every output:
  - S1: register color_index, videoOn, hsync_in, vsync_in; synchronous read of palette[color_index]. Also register whether the index is >= PAL_DEPTH.
  - S2:
    - If S1 videoOn=0: RGB=0, de_out=0.
    - Else if out of range: RGB=OOB_COLOR, de_out=1; oob_flag is set.
    - Else: RGB=palette entry, de_out=1.
    - Syncs are passed through S2 from S1.
  - Sample at cycle t appears on the outputs at edge t+2; each pixel is independent (no stale-stage carry-over).
- Write/read collision: a write and lookup to the same address in the same cycle returns the OLD value (read-before-write); the new value is visible for lookups issued one cycle later.
- Sticky flags:
  - err_clr clears both flags.
  - err_clr has priority over a same-cycle set.
  - Out-of-range indices during blanking do not set oob_flag.
- INIT to RUN transition: the first lookup sampled in RUN appears 2 cycles later. Output stays black/idle in between.
- Width rules:
  - Index compare is unsigned against PAL_DEPTH.
  - Init counter width is $clog2(PAL_DEPTH+1).
  - Palette storage is PAL_DEPTH x 3*CH_W and must infer RAM when PAL_DEPTH > 16.

Decomposition:
- Package display_pkg:
  - rgb_t struct {r,g,b} of CH_W.
  - pp_state_e {INIT, RUN}.
  - Shared constant BLACK.
- Sub-module palette_ram:
  - Single write port, single synchronous read port, read-before-write.
  - Instanced once.
  - Keeps RAM inference isolated from the FSM and pipeline.

Test Plan:
- Release rst, PAL_DEPTH=10 -> pal_ready rises after exactly 10 cycles; during INIT, RGB=0 and hsync_out=vsync_out=1 despite toggling inputs.
- In RUN:
  - Stimulus: write entry 3=24'h12AB34, then drive index 3 with videoOn=1 and hsync_in pulse at cycle t.
  - Response: at t+2, red=12, green=AB, blue=34, de_out=1, hsync_out pulses.
- Same cycle: write entry 5=24'hFFFFFF, old entry 5=24'h000080, lookup index 5 -> output 000080; repeat lookup next cycle -> FFFFFF.
- Index 12 with videoOn=1 -> RGB=FF00FF, oob_flag=1 persists; index 12 with videoOn=0 -> RGB=0, no flag; err_clr -> flag 0.
- pal_we to addr 10 -> no entry changes, wr_err=1; pal_we during INIT -> dropped, entry still 0 after INIT.
- Assert rst during a stream in RUN -> outputs 0/idle immediately, INIT repeats for 10 cycles, previously written entry 3 reads back 0.
